ddr_cmd_decoder: RTL and testbench

Front-end stage feeding TimingFSM: samples raw DDR4 command/address pins once per clock and decodes them into the one-hot command strobes with bank-group/bank that TimingFSM consumes. It tracks CKE for power-down and self-refresh entry/exit, keeps shadow copies of MR0–MR6, and flags illegal commands. With the configuration macro defined, it also checks command/address parity.

---
 rtl/ddr_cmd_pkg.sv | 43 ++++
 rtl/ddr_cmd_decoder_parity.sv | 41 ++++
 rtl/ddr_cmd_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ddr_cmd_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared types and constants for the DDR4 command decoder front end.
package ddr_cmd_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE  = 2'd0,
    PWR_PWRDN   = 2'd1,
    PWR_SELFREF = 2'd2
  } pwr_state_t;

  // {RAS_n, CAS_n, WE_n} pin codes (A16/A15/A14) when ACT_n is high.
  localparam logic [2:0] RCW_MRW  = 3'b000;
  localparam logic [2:0] RCW_REF  = 3'b001;
  localparam logic [2:0] RCW_PRE  = 3'b010;
  localparam logic [2:0] RCW_RSVD = 3'b011;
  localparam logic [2:0] RCW_WR   = 3'b100;
  localparam logic [2:0] RCW_RD   = 3'b101;
  localparam logic [2:0] RCW_ZQ   = 3'b110;
  localparam logic [2:0] RCW_NOP  = 3'b111;

  localparam int         MR_COUNT   = 7;
  localparam logic [2:0] MR_IDX_MAX = 3'd6;

  localparam int ALERT_PW_DEFAULT = 4;

  typedef struct packed {
    logic act;
    logic cfg;
    logic ckeh;
    logic ckel;
    logic mrw;
    logic pd;
    logic pdx;
    logic pr;
    logic pra;
    logic rd;
    logic rda;
    logic ref_cmd;
    logic srf;
    logic wr;
    logic wra;
  } strobe_t;

endpackage

// File: rtl/ddr_cmd_decoder_parity.sv
// Command/address even-parity checker with a restartable alert_n low pulse.
// Only instantiated when PARITY_EN is defined.
module ddr_cmd_parity #(
  parameter int W        = 23,
  parameter int ALERT_PW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         check_i,
  input  logic [W-1:0] bits_i,
  output logic         par_err_o,
  output logic         alert_n_o
);

  localparam int CW = $clog2(ALERT_PW + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // bits_i already includes the par pin, so a good command XORs to zero.
  assign par_err_o = check_i && (^bits_i);

  always_comb begin
    cnt_d = cnt_q;
    if (par_err_o) begin
      cnt_d = CW'(ALERT_PW);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign alert_n_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR4 command pin decoder: one-cycle registered strobes, CKE power tracking,
// MR0-MR6 shadows. Define PARITY_EN to enable command/address parity checking.
module ddr_cmd_decoder
  import ddr_cmd_pkg::*;
#(
  parameter int  BGWIDTH   = 2,
  parameter int  BAWIDTH   = 2,
  parameter int  ADDRWIDTH = 14,
  parameter int  ALERT_PW  = ALERT_PW_DEFAULT,
  localparam int BGW       = (BGWIDTH > 0) ? BGWIDTH : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic                           cs_n,
  input  logic                           act_n,
  input  logic                           ras_n,
  input  logic                           cas_n,
  input  logic                           we_n,
  input  logic [BGW-1:0]                 bg_in,
  input  logic [BAWIDTH-1:0]             ba_in,
  input  logic [ADDRWIDTH-1:0]           addr,
  input  logic                           par,
  output logic                           ACT,
  output logic                           BST,
  output logic                           CFG,
  output logic                           CKEH,
  output logic                           CKEL,
  output logic                           DPD,
  output logic                           DPDX,
  output logic                           MRR,
  output logic                           MRW,
  output logic                           PD,
  output logic                           PDX,
  output logic                           PR,
  output logic                           PRA,
  output logic                           RD,
  output logic                           RDA,
  output logic                           REF,
  output logic                           SRF,
  output logic                           WR,
  output logic                           WRA,
  output logic [BGW-1:0]                 bg,
  output logic [BAWIDTH-1:0]             ba,
  output logic [ADDRWIDTH-1:0]           row,
  output logic [9:0]                     col,
  output logic [MR_COUNT-1:0][ADDRWIDTH-1:0] mode_reg,
  output logic [1:0]                     pwr_state,
  output logic                           illegal,
  output logic                           alert_n
);

  strobe_t        strb_d, strb_q;
  logic           illegal_d, illegal_q;
  pwr_state_t     pwr_d, pwr_q;
  logic           cke_prev_q;
  logic [BGW-1:0] bg_q;
  logic [BAWIDTH-1:0] ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [9:0]     col_q;
  logic [MR_COUNT-1:0][ADDRWIDTH-1:0] mr_q;
  logic           mr_we;
  logic [2:0]     mr_idx;
  logic [2:0]     rcw;
  logic           cmd_nop;
  logic           par_err;
  logic [BGW-1:0] bg_pins;

  assign rcw     = {ras_n, cas_n, we_n};
  assign cmd_nop = act_n && (rcw == RCW_NOP);
  assign bg_pins = (BGWIDTH > 0) ? bg_in : '0;

  always_comb begin
    mr_idx = {1'b0, 2'(ba_in)};
    if (BGWIDTH > 0) mr_idx[2] = bg_in[0];
  end

`ifdef PARITY_EN
  localparam int PW = 4 + BGW + BAWIDTH + ADDRWIDTH + 1;

  ddr_cmd_parity #(
    .W        (PW),
    .ALERT_PW (ALERT_PW)
  ) u_parity (
    .clk       (clk),
    .reset     (reset),
    .check_i   (!cs_n),
    .bits_i    ({act_n, ras_n, cas_n, we_n, bg_pins, ba_in, addr, par}),
    .par_err_o (par_err),
    .alert_n_o (alert_n)
  );
`else
  localparam int unused_alert_pw = ALERT_PW;
  logic unused_par;
  assign unused_par = par;
  assign par_err    = 1'b0;
  assign alert_n    = 1'b1;
`endif

  always_comb begin
    strb_d    = '0;
    illegal_d = 1'b0;
    pwr_d     = pwr_q;
    mr_we     = 1'b0;
    unique case (pwr_q)
      PWR_ACTIVE: begin
        if (!cs_n && par_err) begin
          illegal_d = 1'b1;
        end else if (cke_prev_q && !cke) begin
          // CKE falling wins over decode: only NOP/deselect or REF may ride it.
          if (cs_n || cmd_nop) begin
            strb_d.pd   = 1'b1;
            strb_d.ckel = 1'b1;
            pwr_d       = PWR_PWRDN;
          end else if (act_n && rcw == RCW_REF) begin
            strb_d.srf  = 1'b1;
            strb_d.ckel = 1'b1;
            pwr_d       = PWR_SELFREF;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (cke_prev_q && cke && !cs_n) begin
          if (!act_n) begin
            strb_d.act = 1'b1;
          end else begin
            unique case (rcw)
              RCW_MRW:  begin strb_d.mrw = 1'b1; mr_we = 1'b1; end
              RCW_REF:  strb_d.ref_cmd = 1'b1;
              RCW_PRE:  if (addr[10]) strb_d.pra = 1'b1; else strb_d.pr = 1'b1;
              RCW_RSVD: illegal_d = 1'b1;
              RCW_WR:   if (addr[10]) strb_d.wra = 1'b1; else strb_d.wr = 1'b1;
              RCW_RD:   if (addr[10]) strb_d.rda = 1'b1; else strb_d.rd = 1'b1;
              RCW_ZQ:   strb_d.cfg = 1'b1;
              default:  ;
            endcase
          end
        end
      end
      PWR_PWRDN: begin
        if (!cke_prev_q && cke) begin
          strb_d.pdx  = 1'b1;
          strb_d.ckeh = 1'b1;
          pwr_d       = PWR_ACTIVE;
        end else if (!cs_n && (!cmd_nop || par_err)) begin
          illegal_d = 1'b1;
        end
      end
      PWR_SELFREF: begin
        if (!cke_prev_q && cke) begin
          strb_d.ckeh = 1'b1;
          pwr_d       = PWR_ACTIVE;
        end else if (!cs_n && (!cmd_nop || par_err)) begin
          illegal_d = 1'b1;
        end
      end
      default: pwr_d = PWR_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strb_q     <= '0;
      illegal_q  <= 1'b0;
      pwr_q      <= PWR_ACTIVE;
      cke_prev_q <= 1'b1;
      bg_q       <= '0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mr_q       <= '0;
    end else begin
      strb_q     <= strb_d;
      illegal_q  <= illegal_d;
      pwr_q      <= pwr_d;
      cke_prev_q <= cke;
      if (|strb_d) begin
        bg_q <= bg_pins;
        ba_q <= ba_in;
      end
      if (strb_d.act) row_q <= addr;
      if (strb_d.rd || strb_d.rda || strb_d.wr || strb_d.wra) col_q <= addr[9:0];
      if (mr_we && mr_idx <= MR_IDX_MAX) mr_q[mr_idx] <= addr;
    end
  end

  assign ACT  = strb_q.act;
  assign CFG  = strb_q.cfg;
  assign CKEH = strb_q.ckeh;
  assign CKEL = strb_q.ckel;
  assign MRW  = strb_q.mrw;
  assign PD   = strb_q.pd;
  assign PDX  = strb_q.pdx;
  assign PR   = strb_q.pr;
  assign PRA  = strb_q.pra;
  assign RD   = strb_q.rd;
  assign RDA  = strb_q.rda;
  assign REF  = strb_q.ref_cmd;
  assign SRF  = strb_q.srf;
  assign WR   = strb_q.wr;
  assign WRA  = strb_q.wra;
  assign BST  = 1'b0;
  assign MRR  = 1'b0;
  assign DPD  = 1'b0;
  assign DPDX = 1'b0;

  assign bg        = bg_q;
  assign ba        = ba_q;
  assign row       = row_q;
  assign col       = col_q;
  assign mode_reg  = mr_q;
  assign pwr_state = pwr_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Table-driven bench for ddr_cmd_decoder; the PARITY_EN build adds alert checks.
module tb_ddr_cmd_decoder;

  logic clk = 1'b0;
  logic reset, cke, cs_n, act_n, ras_n, cas_n, we_n, par;
  logic [1:0] bg_in, ba_in;
  logic [13:0] addr;
  logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA;
  logic RD, RDA, REF, SRF, WR, WRA;
  logic [1:0] bg, ba, pwr_state;
  logic [13:0] row;
  logic [9:0] col;
  logic [6:0][13:0] mode_reg;
  logic illegal, alert_n;
  logic [18:0] strb;

  int checks = 0;
  int errors = 0;

  localparam logic [18:0] S_NONE = 19'h00000;
  localparam logic [18:0] S_ACT  = 19'h40000;
  localparam logic [18:0] S_CFG  = 19'h10000;
  localparam logic [18:0] S_CKEH = 19'h08000;
  localparam logic [18:0] S_CKEL = 19'h04000;
  localparam logic [18:0] S_MRW  = 19'h00400;
  localparam logic [18:0] S_PD   = 19'h00200;
  localparam logic [18:0] S_PDX  = 19'h00100;
  localparam logic [18:0] S_PR   = 19'h00080;
  localparam logic [18:0] S_PRA  = 19'h00040;
  localparam logic [18:0] S_RD   = 19'h00020;
  localparam logic [18:0] S_REF  = 19'h00008;
  localparam logic [18:0] S_SRF  = 19'h00004;
  localparam logic [18:0] S_WRA  = 19'h00001;

  ddr_cmd_decoder #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(14), .ALERT_PW(4)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg_in(bg_in), .ba_in(ba_in),
    .addr(addr), .par(par),
    .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD),
    .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA),
    .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA),
    .bg(bg), .ba(ba), .row(row), .col(col), .mode_reg(mode_reg),
    .pwr_state(pwr_state), .illegal(illegal), .alert_n(alert_n)
  );

  assign strb = {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX,
                 PR, PRA, RD, RDA, REF, SRF, WR, WRA};

  always #5 clk = ~clk;

  typedef struct {
    logic        cke, cs_n, act_n;
    logic [2:0]  rcw;
    logic [1:0]  bg, ba;
    logic [13:0] addr;
    logic [18:0] exp_strb;
    logic        exp_ill;
    logic [1:0]  exp_pwr, exp_bg, exp_ba;
    logic [13:0] exp_row;
    logic [9:0]  exp_col;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic ck, cs, an, input logic [2:0] r,
                              input logic [1:0] g, b, input logic [13:0] a,
                              input logic [18:0] s, input logic il,
                              input logic [1:0] pw, eg, eb,
                              input logic [13:0] er, input logic [9:0] ec);
    vec_t v;
    v.cke = ck; v.cs_n = cs; v.act_n = an; v.rcw = r; v.bg = g; v.ba = b;
    v.addr = a; v.exp_strb = s; v.exp_ill = il; v.exp_pwr = pw;
    v.exp_bg = eg; v.exp_ba = eb; v.exp_row = er; v.exp_col = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  // Even parity: the par pin makes the XOR over all checked pins zero.
  task automatic drive(input logic ck, cs, an, input logic [2:0] r,
                       input logic [1:0] g, b, input logic [13:0] a,
                       input logic bad_par);
    cke = ck; cs_n = cs; act_n = an; {ras_n, cas_n, we_n} = r;
    bg_in = g; ba_in = b; addr = a;
    par = (^{an, r, g, b, a}) ^ bad_par;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0, 1'b0);
    repeat (2) step();
    chk("rst_strb", 32'(strb), 32'(S_NONE));
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_pwr", 32'(pwr_state), 32'd0);
    chk("rst_alert", 32'(alert_n), 32'd1);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_bgba", 32'({bg, ba}), 32'd0);
    reset = 1'b0;

    //             cke  cs   act  rcw     bg ba addr       strobe          ill pwr bg ba row       col
    vecs[0]  = mk(1, 0, 0, 3'b111, 1, 1, 14'h1234, S_ACT,           0, 0, 1, 1, 14'h1234, 10'h000);
    vecs[1]  = mk(1, 0, 1, 3'b100, 0, 2, 14'h0555, S_WRA,           0, 0, 0, 2, 14'h1234, 10'h155);
    vecs[2]  = mk(1, 0, 1, 3'b101, 2, 3, 14'h0123, S_RD,            0, 0, 2, 3, 14'h1234, 10'h123);
    vecs[3]  = mk(1, 0, 1, 3'b000, 0, 1, 14'h0A2D, S_MRW,           0, 0, 0, 1, 14'h1234, 10'h123);
    vecs[4]  = mk(1, 0, 1, 3'b010, 1, 0, 14'h0000, S_PR,            0, 0, 1, 0, 14'h1234, 10'h123);
    vecs[5]  = mk(1, 0, 1, 3'b010, 0, 3, 14'h0400, S_PRA,           0, 0, 0, 3, 14'h1234, 10'h123);
    vecs[6]  = mk(1, 0, 1, 3'b001, 3, 2, 14'h0000, S_REF,           0, 0, 3, 2, 14'h1234, 10'h123);
    vecs[7]  = mk(1, 0, 1, 3'b110, 1, 1, 14'h0400, S_CFG,           0, 0, 1, 1, 14'h1234, 10'h123);
    vecs[8]  = mk(1, 0, 1, 3'b111, 2, 2, 14'h0000, S_NONE,          0, 0, 1, 1, 14'h1234, 10'h123);
    vecs[9]  = mk(1, 1, 1, 3'b000, 3, 3, 14'h0000, S_NONE,          0, 0, 1, 1, 14'h1234, 10'h123);
    vecs[10] = mk(1, 0, 1, 3'b011, 0, 0, 14'h0000, S_NONE,          1, 0, 1, 1, 14'h1234, 10'h123);
    vecs[11] = mk(0, 1, 1, 3'b111, 2, 1, 14'h0000, S_PD | S_CKEL,   0, 1, 2, 1, 14'h1234, 10'h123);
    vecs[12] = mk(0, 0, 1, 3'b101, 0, 0, 14'h0000, S_NONE,          1, 1, 2, 1, 14'h1234, 10'h123);
    vecs[13] = mk(0, 0, 1, 3'b111, 0, 0, 14'h0000, S_NONE,          0, 1, 2, 1, 14'h1234, 10'h123);
    vecs[14] = mk(1, 1, 1, 3'b111, 1, 2, 14'h0000, S_PDX | S_CKEH,  0, 0, 1, 2, 14'h1234, 10'h123);
    vecs[15] = mk(1, 0, 1, 3'b101, 3, 0, 14'h03FF, S_RD,            0, 0, 3, 0, 14'h1234, 10'h3FF);
    vecs[16] = mk(0, 0, 1, 3'b001, 0, 1, 14'h0000, S_SRF | S_CKEL,  0, 2, 0, 1, 14'h1234, 10'h3FF);
    vecs[17] = mk(0, 0, 1, 3'b101, 2, 2, 14'h0000, S_NONE,          1, 2, 0, 1, 14'h1234, 10'h3FF);
    vecs[18] = mk(1, 1, 1, 3'b111, 1, 3, 14'h0000, S_CKEH,          0, 0, 1, 3, 14'h1234, 10'h3FF);
    vecs[19] = mk(0, 0, 0, 3'b111, 2, 2, 14'h0F0F, S_NONE,          1, 0, 1, 3, 14'h1234, 10'h3FF);
    vecs[20] = mk(1, 0, 0, 3'b111, 2, 2, 14'h0F0F, S_NONE,          0, 0, 1, 3, 14'h1234, 10'h3FF);
    vecs[21] = mk(1, 0, 0, 3'b111, 2, 0, 14'h0F0F, S_ACT,           0, 0, 2, 0, 14'h0F0F, 10'h3FF);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].cke, vecs[i].cs_n, vecs[i].act_n, vecs[i].rcw,
            vecs[i].bg, vecs[i].ba, vecs[i].addr, 1'b0);
      step();
      chk($sformatf("v%0d_strb", i), 32'(strb), 32'(vecs[i].exp_strb));
      chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].exp_ill));
      chk($sformatf("v%0d_pwr", i), 32'(pwr_state), 32'(vecs[i].exp_pwr));
      chk($sformatf("v%0d_bgba", i), 32'({bg, ba}), 32'({vecs[i].exp_bg, vecs[i].exp_ba}));
      chk($sformatf("v%0d_row", i), 32'(row), 32'(vecs[i].exp_row));
      chk($sformatf("v%0d_col", i), 32'(col), 32'(vecs[i].exp_col));
      chk($sformatf("v%0d_alert", i), 32'(alert_n), 32'd1);
    end

    for (int m = 0; m < 7; m++) begin
      chk($sformatf("mr%0d", m), 32'(mode_reg[m]), (m == 1) ? 32'h0A2D : 32'h0);
    end

    // Reset lands while a PD/CKEL strobe is registered and the FSM is in PWRDN.
    drive(1'b0, 1'b1, 1'b1, 3'b111, 2'd1, 2'd1, 14'h0, 1'b0);
    step();
    chk("pre_rst_strb", 32'(strb), 32'(S_PD | S_CKEL));
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b111, 2'd3, 2'd3, 14'h3FFF, 1'b0);
    step();
    chk("mid_rst_strb", 32'(strb), 32'(S_NONE));
    chk("mid_rst_pwr", 32'(pwr_state), 32'd0);
    chk("mid_rst_row", 32'(row), 32'd0);
    chk("mid_rst_col", 32'(col), 32'd0);
    chk("mid_rst_mr1", 32'(mode_reg[1]), 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b101, 2'd2, 2'd1, 14'h0077, 1'b0);
    step();
    chk("post_rst_strb", 32'(strb), 32'(S_RD));
    chk("post_rst_col", 32'(col), 32'h077);
    chk("post_rst_bgba", 32'({bg, ba}), 32'({2'd2, 2'd1}));

`ifdef PARITY_EN
    drive(1'b1, 1'b0, 1'b0, 3'b111, 2'd1, 2'd1, 14'h1234, 1'b1);
    step();
    chk("par_act_strb", 32'(strb), 32'(S_NONE));
    chk("par_ill", 32'(illegal), 32'd1);
    chk("par_alert0", 32'(alert_n), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("par_alert%0d", k), 32'(alert_n), 32'd0);
    end
    step();
    chk("par_alert_end", 32'(alert_n), 32'd1);
    chk("par_ill_end", 32'(illegal), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 2'd0, 14'h0001, 1'b1);
    step();
    chk("par2_alert", 32'(alert_n), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0, 1'b0);
    step();
    reset = 1'b1;
    step();
    chk("par_rst_alert", 32'(alert_n), 32'd1);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
